// File: rtl/tdc_delay_capture_core.sv
// Time-to-digital converter core: pulse source, delay line, snapshot,
// synchronizer and registered popcount of the captured thermometer code.
module tdc_delay_capture_core #(
  parameter int    N          = 64,
  parameter string DL_TYPE    = "DAND",
  parameter int    N_SYNC     = 1,
  parameter string POP_METHOD = "SV"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             launch,
  input  logic             capture,
  input  logic             pg_src,
  input  logic             pg_bypass,
  input  logic             pg_in,
  input  logic             pg_tog,
  output logic [$clog2(N):0] hw
);

  localparam int HW_W    = $clog2(N) + 1;
  localparam int LG      = $clog2(N);
  localparam int P       = 1 << LG;
  localparam bit IS_DAND = (DL_TYPE == "DAND");
  localparam bit IS_TREE = (POP_METHOD == "TREE");

  logic            tog_q;
  logic            launch_q;
  logic            pg_sel;
  logic            dl_in;
  logic [N-1:0]    d;
  logic [N-1:0]    d_nxt;
  logic [N-1:0]    snap;
  logic [N-1:0]    pop_src;
  logic [HW_W-1:0] pop_cnt;

  assign pg_sel = pg_src ? tog_q : pg_in;
  assign dl_in  = pg_bypass ? pg_sel : launch_q;

  // DAND stages are gated by the line input, so a low input empties the line
  if (IS_DAND) begin : g_dand
    assign d_nxt = {d[N-2:0] & {(N-1){dl_in}}, dl_in};
  end else begin : g_rca
    assign d_nxt = {d[N-2:0], dl_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_q    <= 1'b0;
      launch_q <= 1'b0;
      d        <= '0;
      snap     <= '0;
    end else if (en) begin
      if (pg_tog)  tog_q    <= ~tog_q;
      if (launch)  launch_q <= pg_sel;
      d <= d_nxt;
      if (capture) snap     <= d;
    end
  end

  if (N_SYNC == 0) begin : g_nosync
    assign pop_src = snap;
  end else begin : g_sync
    logic [N-1:0] s_q [N_SYNC];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < N_SYNC; i++) s_q[i] <= '0;
      end else if (en) begin
        s_q[0] <= snap;
        for (int i = 1; i < N_SYNC; i++) s_q[i] <= s_q[i-1];
      end
    end

    assign pop_src = s_q[N_SYNC-1];
  end

  if (IS_TREE) begin : g_tree
    // Leaves padded to a power of two; each level halves the node count
    for (genvar l = 0; l <= LG; l++) begin : g_lvl
      logic [HW_W-1:0] v [P>>l];
      for (genvar i = 0; i < (P >> l); i++) begin : g_n
        if (l == 0) begin : g_leaf
          if (i < N) begin : g_bit
            assign v[i] = HW_W'(pop_src[i]);
          end else begin : g_pad
            assign v[i] = '0;
          end
        end else begin : g_add
          assign v[i] = g_lvl[l-1].v[2*i] + g_lvl[l-1].v[2*i+1];
        end
      end
    end
    assign pop_cnt = g_lvl[LG].v[0];
  end else begin : g_loop
    always_comb begin
      pop_cnt = '0;
      for (int i = 0; i < N; i++) pop_cnt = pop_cnt + HW_W'(pop_src[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  hw <= '0;
    else if (en) hw <= pop_cnt;
  end

endmodule

// File: tb/tb_tdc_delay_capture_core.sv
// Bench for tdc_delay_capture_core: five configurations share one stimulus,
// expected codes queued at capture and compared as each output arrives.
module tb_tdc_delay_capture_core;

  typedef struct {
    int dand;
    int rca;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, en, launch, capture;
  logic pg_src, pg_bypass, pg_in, pg_tog;

  // 0 dand/sv, 1 rca/sv, 2 rca/tree, 3 dand nsync0, 4 dand nsync3
  logic [6:0] hw_w [5];
  string      nm [5] = '{"dand", "rca", "rca_tree", "sync0", "sync3"};

  exp_t sb [$];
  exp_t prev;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tdc_delay_capture_core u_dand (
    .clk(clk), .rst_n(rst_n), .en(en), .launch(launch), .capture(capture),
    .pg_src(pg_src), .pg_bypass(pg_bypass), .pg_in(pg_in), .pg_tog(pg_tog),
    .hw(hw_w[0]));

  tdc_delay_capture_core #(.DL_TYPE("RCA")) u_rca (
    .clk(clk), .rst_n(rst_n), .en(en), .launch(launch), .capture(capture),
    .pg_src(pg_src), .pg_bypass(pg_bypass), .pg_in(pg_in), .pg_tog(pg_tog),
    .hw(hw_w[1]));

  tdc_delay_capture_core #(.DL_TYPE("RCA"), .POP_METHOD("TREE")) u_tree (
    .clk(clk), .rst_n(rst_n), .en(en), .launch(launch), .capture(capture),
    .pg_src(pg_src), .pg_bypass(pg_bypass), .pg_in(pg_in), .pg_tog(pg_tog),
    .hw(hw_w[2]));

  tdc_delay_capture_core #(.N_SYNC(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .en(en), .launch(launch), .capture(capture),
    .pg_src(pg_src), .pg_bypass(pg_bypass), .pg_in(pg_in), .pg_tog(pg_tog),
    .hw(hw_w[3]));

  tdc_delay_capture_core #(.N_SYNC(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .en(en), .launch(launch), .capture(capture),
    .pg_src(pg_src), .pg_bypass(pg_bypass), .pg_in(pg_in), .pg_tog(pg_tog),
    .hw(hw_w[4]));

  function automatic int exp_of(exp_t e, int i);
    return (i == 1 || i == 2) ? e.rca : e.dand;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One capture edge, then follow the result through each pipeline depth
  task automatic capture_and_drain(string tag, int e_dand, int e_rca);
    exp_t cur;
    int   want;
    sb.push_back('{e_dand, e_rca});
    capture = 1'b1;
    tick();
    capture = 1'b0;
    tick();
    cur = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      want = (i == 3) ? cur.dand : (i == 4) ? prev.dand : exp_of(prev, i);
      n_cmp++;
      if (hw_w[i] !== 7'(want)) begin
        n_bad++;
        $display("FAIL %s/%s@+1: got %0d want %0d", tag, nm[i], hw_w[i], want);
      end
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      want = (i == 4) ? prev.dand : exp_of(cur, i);
      n_cmp++;
      if (hw_w[i] !== 7'(want)) begin
        n_bad++;
        $display("FAIL %s/%s@+2: got %0d want %0d", tag, nm[i], hw_w[i], want);
      end
    end
    tick();
    n_cmp++;
    if (hw_w[4] !== 7'(prev.dand)) begin
      n_bad++;
      $display("FAIL %s/sync3@+3: got %0d want %0d", tag, hw_w[4], prev.dand);
    end
    tick();
    n_cmp++;
    if (hw_w[4] !== 7'(cur.dand)) begin
      n_bad++;
      $display("FAIL %s/sync3@+4: got %0d want %0d", tag, hw_w[4], cur.dand);
    end
    prev = cur;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; launch = 1'b0; capture = 1'b0;
    pg_src = 1'b0; pg_bypass = 1'b1; pg_in = 1'b0; pg_tog = 1'b0;
    prev = '{0, 0};
    tick(3);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (hw_w[i] !== 7'd0) begin
        n_bad++;
        $display("FAIL reset/%s: got %0d want 0", nm[i], hw_w[i]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bypass_fill();
    pg_src = 1'b0; pg_bypass = 1'b1; pg_in = 1'b1;
    tick(10);
    capture_and_drain("fill10", 10, 10);
    tick(100);
    capture_and_drain("fill_full", 64, 64);
  endtask

  task automatic test_drain();
    pg_in = 1'b0;
    tick();
    capture_and_drain("drop1", 0, 63);
    pg_in = 1'b1;
    tick(70);
    pg_in = 1'b0;
    tick(10);
    capture_and_drain("drop10", 0, 54);
  endtask

  task automatic test_toggle_launch();
    pg_src = 1'b1; pg_bypass = 1'b0; pg_in = 1'b0;
    tick(70);
    capture_and_drain("no_launch", 0, 0);
    pg_tog = 1'b1;
    tick();
    pg_tog = 1'b0;
    launch = 1'b1;
    tick();
    launch = 1'b0;
    tick(5);
    capture_and_drain("launch5", 5, 5);
  endtask

  task automatic test_enable_freeze();
    pg_src = 1'b0; pg_bypass = 1'b1; pg_in = 1'b0;
    tick(70);
    pg_in = 1'b1;
    tick(20);
    en = 1'b0;
    capture = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (hw_w[i] !== 7'(exp_of(prev, i))) begin
          n_bad++;
          $display("FAIL freeze/%s: got %0d want %0d", nm[i], hw_w[i],
                   exp_of(prev, i));
        end
      end
    end
    en = 1'b1;
    capture_and_drain("unfreeze", 20, 20);
  endtask

  task automatic test_reset_midrun();
    pg_in = 1'b1;
    tick(70);
    capture_and_drain("pre_reset", 64, 64);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (hw_w[i] !== 7'd0) begin
        n_bad++;
        $display("FAIL async_reset/%s: got %0d want 0", nm[i], hw_w[i]);
      end
    end
    prev = '{0, 0};
    tick();
    rst_n = 1'b1;
    pg_in = 1'b0;
    capture_and_drain("post_reset", 0, 0);
  endtask

  task automatic test_pop_equiv();
    logic [63:0] m;
    int          run;
    logic        b;
    pg_src = 1'b0; pg_bypass = 1'b1;
    for (int r = 0; r < 6; r++) begin
      m = '0;
      run = 0;
      pg_in = 1'b0;
      tick();
      for (int k = 0; k < 64 + r * 3; k++) begin
        b = (r == 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
        pg_in = b;
        tick();
        m = {m[62:0], b};
        run = b ? run + 1 : 0;
      end
      capture_and_drain("rand", (run > 64) ? 64 : run, $countones(m));
    end
  endtask

  initial begin
    test_reset();
    test_bypass_fill();
    test_drain();
    test_toggle_launch();
    test_enable_freeze();
    test_reset_midrun();
    test_pop_equiv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdc_delay_capture_core.md
Name: tdc_delay_capture_core

Overview:
- Synthesizable, single-clock time-to-digital converter (TDC) core.
- A selectable pulse source drives an N-stage delay line. A capture strobe snapshots the line as a thermometer code, and the number of ones is reported as a Hamming weight `hw`.
- Sits directly under the chip top, which maps raw pins to its control inputs and drives `hw` onto the output pins.

Parameters:
- N, 64: number of delay-line stages; any value ≥ 2.
- DL_TYPE, "DAND": delay element type. "RCA" = plain shift stage; "DAND" = stage gated by the line input. Any other value is treated as "RCA".
- N_SYNC, 1: number of synchronizer register stages between snapshot and popcount; 0 allowed.
- POP_METHOD, "SV": popcount implementation. "SV" = loop sum; "TREE" = pairwise adder tree. Results must be bit-identical.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: global enable; all registers hold when low.
- launch, input, 1: launch strobe, sampled by clk.
- capture, input, 1: capture strobe, sampled by clk.
- pg_src, input, 1: pulse source select; 1 = internal toggle register, 0 = pg_in.
- pg_bypass, input, 1: 1 = feed the selected source straight into the delay line, bypassing the launch register.
- pg_in, input, 1: external pulse level.
- pg_tog, input, 1: toggle request for the internal source.
- hw, output, clog2(N)+1: Hamming weight of the captured code, range 0..N.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following clear to 0 immediately: tog_q, launch_q, delay stages d[N-1:0], snapshot, sync stages, hw.
- Enable: when en=0, every register holds its value; all updates below apply only when en=1.
- Toggle source: tog_q <= ~tog_q on each edge where pg_tog=1.
- Source select: pg_sel = pg_src ? tog_q : pg_in (combinational).
- Launch register: launch_q <= pg_sel on edges where launch=1; otherwise it holds.
- Line input: dl_in = pg_bypass ? pg_sel : launch_q (combinational).
- RCA delay line: d[0] <= dl_in; d[i] <= d[i-1] for i = 1..N-1.
- DAND delay line: d[0] <= dl_in; d[i] <= d[i-1] & dl_in. A 0 on dl_in clears every stage on the next edge.
- Thermometer fill: with dl_in held at 1 for k consecutive edges from an all-zero line, d holds min(k,N) ones in the low bits. The line saturates at all ones; there is no wrap-around.
- Snapshot: on an edge with capture=1, snap <= d, using the pre-edge value of d. Without capture, snap holds.
- Simultaneous launch and capture: capture sees the pre-edge line, so the new launch value is not included.
- Sync stages: N_SYNC registers, s0 <= snap, sN <= sN-1, updated every enabled edge.
- Popcount: hw <= popcount(last sync stage), or popcount(snap) when N_SYNC=0. Registered.
- Latency: hw reflects a capture made at edge E on edge E+N_SYNC+1. With default N_SYNC=1, that is 2 edges.
- hw is stable between captures once the pipeline has drained.
- Reset mid-operation: everything clears immediately. The first valid hw after reset needs a fresh capture.
- Width: hw = clog2(N)+1 bits, so hw = N (all ones) is representable. For N=64, hw is 7 bits and the value 64 is 7'b1000000.

Test Plan:
1. Reset: assert rst_n=0 mid-run with the line full → hw=0, line empty, asynchronously and without waiting for a clock.
2. Bypass fill (RCA and DAND, N=64): pg_src=0, pg_bypass=1, pg_in=1 for 10 edges, then capture=1 for one edge → hw=10 two edges after the capture edge. Repeat after 100 edges → hw=64.
3. DAND collapse vs RCA drain: fill the line, drop pg_in to 0 for one edge, then capture → DAND gives hw=0. RCA gives hw=63 after 1 edge and hw=54 after 10 edges.
4. Toggle/launch path: pg_src=1, pg_bypass=0. Pulse pg_tog once (tog_q=1), then pulse launch once; wait 5 edges after launch_q rises, then capture → hw=5. Without the launch pulse → hw=0.
5. Enable freeze: fill the line to 20, drop en for 30 edges, raise en and capture immediately → hw=20. Check hw does not change while en=0.
6. POP_METHOD equivalence: for random line patterns, "SV" and "TREE" instances produce identical hw. Also check N_SYNC=0 gives latency 1 and N_SYNC=3 gives latency 4.
